// File: rtl/trace_cache_monitor_pkg.sv
// Shared definitions for trace_cache_monitor: FSM states and address-field width helpers.
// Optional feature macro: CACHE_MON_DIRTY_EN (per-line dirty tracking, write-back counting).
package trace_cache_monitor_pkg;

    typedef enum logic {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic int off_width(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int sets, input int line_bytes);
        return addr_w - $clog2(sets) - $clog2(line_bytes);
    endfunction

endpackage

// File: rtl/trace_cache_monitor_tag_array.sv
// cache_tag_array: SETS x {valid,[dirty],tag} with one combinational read port, one write port, sweep clear.
// Dirty storage and ports exist only when CACHE_MON_DIRTY_EN is defined.
module cache_tag_array
    import trace_cache_monitor_pkg::*;
#(
    parameter int SETS  = 64,
    parameter int TAG_W = 22,
    parameter int IDX_W = idx_width(SETS)
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic             rd_valid_o,
    output logic [TAG_W-1:0] rd_tag_o,
`ifdef CACHE_MON_DIRTY_EN
    output logic             rd_dirty_o,
    input  logic             wr_dirty_i,
`endif
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    input  logic [TAG_W-1:0] wr_tag_i,
    input  logic             clr_en_i,
    input  logic [IDX_W-1:0] clr_idx_i
);

    // No reset on storage: every line is swept invalid before any lookup is allowed.
    logic [SETS-1:0]  r_valid;
    logic [TAG_W-1:0] r_tag [SETS];

    always_ff @(posedge clk_i) begin
        if (clr_en_i) begin
            r_valid[clr_idx_i] <= 1'b0;
        end else if (wr_en_i) begin
            r_valid[wr_idx_i] <= 1'b1;
            r_tag[wr_idx_i]   <= wr_tag_i;
        end
    end

    assign rd_valid_o = r_valid[rd_idx_i];
    assign rd_tag_o   = r_tag[rd_idx_i];

`ifdef CACHE_MON_DIRTY_EN
    logic [SETS-1:0] r_dirty;

    always_ff @(posedge clk_i) begin
        if (clr_en_i) begin
            r_dirty[clr_idx_i] <= 1'b0;
        end else if (wr_en_i) begin
            r_dirty[wr_idx_i] <= wr_dirty_i;
        end
    end

    assign rd_dirty_o = r_dirty[rd_idx_i];
`endif

endmodule

// File: rtl/trace_cache_monitor.sv
// trace_cache_monitor: direct-mapped cache model over a CPU address stream, per-access hit/miss and totals.
// Define CACHE_MON_DIRTY_EN to enable dirty tracking and the write-back counter.
module trace_cache_monitor
    import trace_cache_monitor_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 64,
    parameter int CNT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic              req_write_i,
    output logic              rsp_valid_o,
    output logic              rsp_hit_o,
    output logic [CNT_W-1:0]  hit_cnt_o,
    output logic [CNT_W-1:0]  miss_cnt_o,
    output logic [CNT_W-1:0]  wb_cnt_o
);

    localparam int OFF_W = off_width(LINE_BYTES);
    localparam int IDX_W = idx_width(SETS);
    localparam int TAG_W = tag_width(ADDR_W, SETS, LINE_BYTES);

    state_t           r_state, w_state_nxt;
    logic [IDX_W-1:0] r_sweep_idx;
    logic             r_rsp_valid, r_rsp_hit;
    logic [CNT_W-1:0] r_hit_cnt, r_miss_cnt;

    logic             w_accept, w_hit, w_sweep_clr, w_wr_en;
    logic [TAG_W-1:0] w_tag, w_rd_tag;
    logic [IDX_W-1:0] w_idx;
    logic             w_rd_valid;

    assign w_tag    = req_addr_i[ADDR_W-1 -: TAG_W];
    assign w_idx    = req_addr_i[OFF_W +: IDX_W];
    assign w_hit    = w_rd_valid & (w_rd_tag == w_tag);
    // A request coinciding with clear_i is dropped even though ready is high.
    assign w_accept = req_valid_i & req_ready_o & ~clear_i;

    assign req_ready_o = (r_state == ST_RUN);

    always_comb begin
        w_state_nxt = r_state;
        w_sweep_clr = 1'b0;
        case (r_state)
            ST_SWEEP: begin
                w_sweep_clr = 1'b1;
                if (!clear_i && r_sweep_idx == IDX_W'(SETS - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (clear_i) begin
                    w_state_nxt = ST_SWEEP;
                end
            end
            default: w_state_nxt = ST_SWEEP;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SWEEP;
            r_sweep_idx <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (clear_i || r_state == ST_RUN) begin
                r_sweep_idx <= '0;
            end else begin
                r_sweep_idx <= r_sweep_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_hit_cnt   <= '0;
            r_miss_cnt  <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_hit   <= w_accept & w_hit;
            if (clear_i) begin
                r_hit_cnt  <= '0;
                r_miss_cnt <= '0;
            end else if (w_accept) begin
                if (w_hit) begin
                    if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_W'(1);
                end else if (r_miss_cnt != '1) begin
                    r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign rsp_valid_o = r_rsp_valid;
    assign rsp_hit_o   = r_rsp_hit;
    assign hit_cnt_o   = r_hit_cnt;
    assign miss_cnt_o  = r_miss_cnt;

`ifdef CACHE_MON_DIRTY_EN
    logic             w_rd_dirty;
    logic             w_unused_off;
    logic [CNT_W-1:0] r_wb_cnt;

    assign w_unused_off = ^req_addr_i[OFF_W-1:0];
    // Lines only need rewriting on a miss or to set dirty on a write hit.
    assign w_wr_en      = w_accept & (~w_hit | req_write_i);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_cnt <= '0;
        end else if (clear_i) begin
            r_wb_cnt <= '0;
        end else if (w_accept && !w_hit && w_rd_valid && w_rd_dirty && r_wb_cnt != '1) begin
            r_wb_cnt <= r_wb_cnt + CNT_W'(1);
        end
    end

    assign wb_cnt_o = r_wb_cnt;
`else
    logic w_unused_off;

    assign w_unused_off = ^{req_addr_i[OFF_W-1:0], req_write_i};
    assign w_wr_en      = w_accept & ~w_hit;
    assign wb_cnt_o     = '0;
`endif

    cache_tag_array #(
        .SETS  (SETS),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_tag_array (
        .clk_i      (clk_i),
        .rd_idx_i   (w_idx),
        .rd_valid_o (w_rd_valid),
        .rd_tag_o   (w_rd_tag),
`ifdef CACHE_MON_DIRTY_EN
        .rd_dirty_o (w_rd_dirty),
        .wr_dirty_i (req_write_i),
`endif
        .wr_en_i    (w_wr_en),
        .wr_idx_i   (w_idx),
        .wr_tag_i   (w_tag),
        .clr_en_i   (w_sweep_clr),
        .clr_idx_i  (r_sweep_idx)
    );

endmodule

// File: tb/tb_trace_cache_monitor.sv
// Self-checking bench for trace_cache_monitor: directed spec scenarios plus random traffic vs a set-array model.
module tb_trace_cache_monitor;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic        rst_n, clear_i, req_valid_i, req_write_i;
    logic [31:0] req_addr_i;
    logic        req_ready_o, rsp_valid_o, rsp_hit_o;
    logic [31:0] hit_cnt_o, miss_cnt_o, wb_cnt_o;

    logic        c4, v4, w4;
    logic [31:0] a4;
    logic        rdy4, rv4, rh4;
    logic [3:0]  h4, m4, wb4;

    int total = 0;
    int bad   = 0;

    trace_cache_monitor dut (
        .clk_i(clk_i), .rst_n(rst_n), .clear_i(clear_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_write_i(req_write_i),
        .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .wb_cnt_o(wb_cnt_o)
    );

    trace_cache_monitor #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .rst_n(rst_n), .clear_i(c4),
        .req_valid_i(v4), .req_ready_o(rdy4),
        .req_addr_i(a4), .req_write_i(w4),
        .rsp_valid_o(rv4), .rsp_hit_o(rh4),
        .hit_cnt_o(h4), .miss_cnt_o(m4), .wb_cnt_o(wb4)
    );

    // Reference model: 64 sets, line = addr/16, set = line%64, tag = addr/1024.
    bit          mv [64];
    int unsigned mt [64];
    bit          md [64];
    longint      m_hit, m_miss, m_wb;
    localparam longint SAT32 = 64'h0000_0000_FFFF_FFFF;

    function automatic void m_clear();
        for (int i = 0; i < 64; i++) begin
            mv[i] = 1'b0;
            md[i] = 1'b0;
        end
        m_hit = 0; m_miss = 0; m_wb = 0;
    endfunction

    function automatic bit m_access(input logic [31:0] a, input bit w);
        int unsigned s = (a / 16) % 64;
        int unsigned t = a / 1024;
        bit h = mv[s] && (mt[s] == t);
        if (h) begin
            if (m_hit < SAT32) m_hit++;
            if (w) md[s] = 1'b1;
        end else begin
            if (mv[s] && md[s] && m_wb < SAT32) m_wb++;
            if (m_miss < SAT32) m_miss++;
            mv[s] = 1'b1; mt[s] = t; md[s] = w;
        end
        return h;
    endfunction

    function automatic logic [31:0] exp_wb();
`ifdef CACHE_MON_DIRTY_EN
        return m_wb[31:0];
`else
        return 32'd0;
`endif
    endfunction

    task automatic wait_ready(output int n);
        n = 0;
        while (req_ready_o !== 1'b1 && n < 200) begin
            @(posedge clk_i); #1;
            n++;
        end
    endtask

    task automatic check_counts(input string nm);
        total++;
        if (hit_cnt_o !== m_hit[31:0] || miss_cnt_o !== m_miss[31:0] || wb_cnt_o !== exp_wb()) begin
            bad++;
            $display("FAIL %s counts: got hit=%0d miss=%0d wb=%0d want hit=%0d miss=%0d wb=%0d",
                     nm, hit_cnt_o, miss_cnt_o, wb_cnt_o, m_hit, m_miss, exp_wb());
        end
    endtask

    // Drives one access for one cycle, checks the response against the model.
    task automatic access(input logic [31:0] a, input bit w, input string nm);
        bit eh;
        req_valid_i = 1'b1; req_addr_i = a; req_write_i = w;
        eh = m_access(a, w);
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        total++;
        if (rsp_valid_o !== 1'b1 || rsp_hit_o !== eh) begin
            bad++;
            $display("FAIL %s rsp addr=%h: got valid=%b hit=%b want valid=1 hit=%b",
                     nm, a, rsp_valid_o, rsp_hit_o, eh);
        end
        check_counts(nm);
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0;
        m_clear();
    endtask

    task automatic test_reset(input string nm);
        int n;
        req_valid_i = 1'b0; clear_i = 1'b0; v4 = 1'b0; c4 = 1'b0;
        rst_n = 1'b0;
        #2;
        total++;
        if (req_ready_o !== 1'b0 || rsp_valid_o !== 1'b0 || rsp_hit_o !== 1'b0 ||
            hit_cnt_o !== 0 || miss_cnt_o !== 0 || wb_cnt_o !== 0) begin
            bad++;
            $display("FAIL %s outputs in reset: got rdy=%b rv=%b rh=%b hit=%0d miss=%0d wb=%0d want all 0",
                     nm, req_ready_o, rsp_valid_o, rsp_hit_o, hit_cnt_o, miss_cnt_o, wb_cnt_o);
        end
        repeat (2) @(posedge clk_i);
        #1 rst_n = 1'b1;
        m_clear();
        wait_ready(n);
        total++;
        if (n != 64) begin
            bad++;
            $display("FAIL %s sweep length: got %0d want 64", nm, n);
        end
        check_counts(nm);
    endtask

    task automatic test_basic();
        access(32'h0000_0000, 1'b0, "basic_rd0");
        access(32'h0000_000C, 1'b0, "basic_rdC");
        total++;
        if (hit_cnt_o !== 32'd1 || miss_cnt_o !== 32'd1) begin
            bad++;
            $display("FAIL basic_totals: got hit=%0d miss=%0d want 1 1", hit_cnt_o, miss_cnt_o);
        end
        repeat (3) begin
            @(posedge clk_i); #1;
            total++;
            if (rsp_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_rsp_valid: got %b want 0", rsp_valid_o);
            end
        end
    endtask

    task automatic test_clear();
        int n;
        // clear with a request in the same cycle: request must be dropped
        req_valid_i = 1'b1; req_addr_i = 32'h0000_000C; req_write_i = 1'b0;
        clear_i = 1'b1;
        @(posedge clk_i); #1;
        clear_i = 1'b0; req_valid_i = 1'b0;
        m_clear();
        total++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL clear_drop: got rv=%b rdy=%b want 0 0", rsp_valid_o, req_ready_o);
        end
        check_counts("clear_zero");
        repeat (10) @(posedge clk_i);
        #1 do_clear();
        wait_ready(n);
        total++;
        if (n != 64) begin
            bad++;
            $display("FAIL clear_sweep_restart: got %0d want 64", n);
        end
        access(32'h0000_000C, 1'b0, "clear_reread");
        total++;
        if (rsp_hit_o !== 1'b0 || miss_cnt_o !== 32'd1) begin
            bad++;
            $display("FAIL clear_reread_miss: got hit=%b miss=%0d want 0 1", rsp_hit_o, miss_cnt_o);
        end
    endtask

    task automatic test_conflict();
        int n;
        do_clear();
        wait_ready(n);
        access(32'h0000_0000, 1'b0, "conf_a");
        access(32'h0000_0400, 1'b0, "conf_b");
        access(32'h0000_0000, 1'b0, "conf_c");
        total++;
        if (miss_cnt_o !== 32'd3 || hit_cnt_o !== 32'd0) begin
            bad++;
            $display("FAIL conflict_totals: got miss=%0d hit=%0d want 3 0", miss_cnt_o, hit_cnt_o);
        end
    endtask

    task automatic test_dirty();
        int n;
        logic [31:0] want;
        do_clear();
        wait_ready(n);
        access(32'h0000_0010, 1'b1, "dirty_wr");
        access(32'h0000_0410, 1'b0, "dirty_rd");
`ifdef CACHE_MON_DIRTY_EN
        want = 32'd1;
`else
        want = 32'd0;
`endif
        total++;
        if (wb_cnt_o !== want || miss_cnt_o !== 32'd2) begin
            bad++;
            $display("FAIL dirty_wb: got wb=%0d miss=%0d want wb=%0d miss=2", wb_cnt_o, miss_cnt_o, want);
        end
    endtask

    task automatic test_back_to_back_random();
        int n;
        logic [31:0] a;
        do_clear();
        wait_ready(n);
        for (int i = 0; i < 1500; i++) begin
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
            if ($urandom_range(0, 3) != 0) begin
                access(a, 1'($urandom_range(0, 1)), "rand");
            end else begin
                @(posedge clk_i); #1;
                total++;
                if (rsp_valid_o !== 1'b0) begin
                    bad++;
                    $display("FAIL rand_idle: got rsp_valid=%b want 0", rsp_valid_o);
                end
            end
        end
    endtask

    task automatic test_saturate();
        int k;
        k = 0;
        while (rdy4 !== 1'b1 && k < 200) begin
            @(posedge clk_i); #1; k++;
        end
        for (int i = 1; i <= 20; i++) begin
            v4 = 1'b1; a4 = (i % 2 == 1) ? 32'h0000_0000 : 32'h0000_0400; w4 = 1'b0;
            @(posedge clk_i); #1;
            v4 = 1'b0;
            if (i == 14 || i == 15 || i == 16 || i == 20) begin
                total++;
                if (m4 !== 4'((i < 15) ? i : 15) || rv4 !== 1'b1 || rh4 !== 1'b0 || h4 !== 4'd0) begin
                    bad++;
                    $display("FAIL sat_miss step %0d: got miss=%0d rv=%b rh=%b hit=%0d want miss=%0d rv=1 rh=0 hit=0",
                             i, m4, rv4, rh4, h4, (i < 15) ? i : 15);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; clear_i = 1'b0; req_valid_i = 1'b0; req_write_i = 1'b0; req_addr_i = '0;
        c4 = 1'b0; v4 = 1'b0; w4 = 1'b0; a4 = '0;
        m_clear();
        test_reset("reset_initial");
        test_basic();
        test_clear();
        test_conflict();
        test_dirty();
        test_back_to_back_random();
        test_reset("reset_midrun");
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
